fetch_controller: RTL and testbench

//   Sequences the instruction-fetch datapath: PC register plus instruction memory.

---
 rtl/fetch_controller_pkg.sv | 17 +
 rtl/fetch_controller_if.sv | 58 +++++
 rtl/fetch_controller_pc_reg.sv | 54 +++++
 rtl/fetch_controller.sv | 181 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
// Optional feature macro: LOAD_CHECKSUM_EN (boot-load checksum verification).
package fetch_ctrl_pkg;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned PC_INC     = 4;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_ERROR  = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Loader, instruction-memory and decode-side signals of the fetch controller.
// Optional feature macro: LOAD_CHECKSUM_EN adds ExpectedSum / ChecksumOk.
interface fetch_controller_if;
   import fetch_ctrl_pkg::*;

   logic                LoadValid;
   logic                LoadReady;
   logic [DATA_W-1:0]   LoadData;
   logic                LoadLast;
   logic                MemWriteEnable;
   logic [ADDR_W-1:0]   MemAddr;
   logic [DATA_W-1:0]   MemWriteData;
   logic                Stall;
   logic                BranchTaken;
   logic [ADDR_W-1:0]   BranchTarget;
   logic                Halt;
   logic                Restart;
   logic [ADDR_W-1:0]   PCAddress;
   logic                FetchValid;
   logic [1:0]          State;
`ifdef LOAD_CHECKSUM_EN
   logic [DATA_W-1:0]   ExpectedSum;
   logic                ChecksumOk;
`endif

`ifdef LOAD_CHECKSUM_EN
   // Controller side
   modport slave (
      input  LoadValid, LoadData, LoadLast, Stall, BranchTaken, BranchTarget,
             Halt, Restart, ExpectedSum,
      output LoadReady, MemWriteEnable, MemAddr, MemWriteData, PCAddress,
             FetchValid, State, ChecksumOk
   );
   // Loader / decode / memory side
   modport master (
      output LoadValid, LoadData, LoadLast, Stall, BranchTaken, BranchTarget,
             Halt, Restart, ExpectedSum,
      input  LoadReady, MemWriteEnable, MemAddr, MemWriteData, PCAddress,
             FetchValid, State, ChecksumOk
   );
`else
   // Controller side
   modport slave (
      input  LoadValid, LoadData, LoadLast, Stall, BranchTaken, BranchTarget,
             Halt, Restart,
      output LoadReady, MemWriteEnable, MemAddr, MemWriteData, PCAddress,
             FetchValid, State
   );
   // Loader / decode / memory side
   modport master (
      output LoadValid, LoadData, LoadLast, Stall, BranchTaken, BranchTarget,
             Halt, Restart,
      input  LoadReady, MemWriteEnable, MemAddr, MemWriteData, PCAddress,
             FetchValid, State
   );
`endif

endinterface

// File: rtl/fetch_controller_pc_reg.sv
// PC register with clear/load/increment and a range check against the
// instruction memory window. An out-of-range update leaves the PC unchanged.
module fetch_pc_reg
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned       MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] next_pc_c_o,
   output logic              out_of_range_c_o
);

   // One extra bit so neither the window end nor PC+4 can wrap.
   localparam logic [ADDR_W:0] LO_ADDR = (ADDR_W+1)'(RESET_PC);
   localparam logic [ADDR_W:0] HI_ADDR = (ADDR_W+1)'(RESET_PC)
                                       + (ADDR_W+1)'(MEM_WORDS) * (ADDR_W+1)'(WORD_BYTES);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W:0]   cand;
   logic              oor;

   // Candidate PC selection and window check
   always_comb begin
      cand = {1'b0, pc_q};
      if (clear_i) begin
         cand = LO_ADDR;
      end else if (load_i) begin
         cand = {1'b0, target_i & ~ADDR_W'(WORD_BYTES - 1)};
      end else if (inc_i) begin
         cand = {1'b0, pc_q} + (ADDR_W+1)'(PC_INC);
      end
      oor  = (load_i || inc_i) && !clear_i && ((cand < LO_ADDR) || (cand >= HI_ADDR));
      pc_d = oor ? pc_q : cand[ADDR_W-1:0];
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_o             = pc_q;
   assign next_pc_c_o      = pc_d;
   assign out_of_range_c_o = oor;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: boot-loads a program into instruction memory,
// then drives the fetch PC (advance, stall, branch, halt, restart).
// Optional feature macro: LOAD_CHECKSUM_EN verifies the sum of loaded words.
module fetch_controller
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned       MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0
) (
   input  logic               Clk,
   input  logic               Rst_n,
   fetch_controller_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(MEM_WORDS) + 1;

   state_e             state_q, state_d;
   logic               load_ready_q, load_ready_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic               fetch_valid_q, fetch_valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pend_q, pend_d;
   state_e             pend_state_q, pend_state_d;
`ifdef LOAD_CHECKSUM_EN
   logic [DATA_W-1:0]  sum_q, sum_d;
   logic               csum_ok_q, csum_ok_d;
`endif

   logic               pc_clear, pc_load, pc_inc;
   logic [ADDR_W-1:0]  pc, next_pc;
   logic               oor;
   logic               fire;

   fetch_pc_reg #(
      .MEM_WORDS (MEM_WORDS),
      .RESET_PC  (RESET_PC)
   ) u_pc (
      .clk              (Clk),
      .rst_n            (Rst_n),
      .clear_i          (pc_clear),
      .load_i           (pc_load),
      .target_i         (bus.BranchTarget),
      .inc_i            (pc_inc),
      .pc_o             (pc),
      .next_pc_c_o      (next_pc),
      .out_of_range_c_o (oor)
   );

   // Ready is only ever high in LOAD before the final word is taken
   assign fire = bus.LoadValid && load_ready_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      load_ready_d  = load_ready_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      fetch_valid_d = fetch_valid_q;
      count_d       = count_q;
      pend_d        = 1'b0;
      pend_state_d  = pend_state_q;
      pc_clear      = 1'b0;
      pc_load       = 1'b0;
      pc_inc        = 1'b0;
`ifdef LOAD_CHECKSUM_EN
      sum_d         = sum_q;
      csum_ok_d     = csum_ok_q;
`endif

      unique case (state_q)
         ST_LOAD: begin
            if (pend_q) begin
               // Final write cycle is done; leave LOAD
               state_d = pend_state_q;
               if (pend_state_q == ST_RUN) begin
                  fetch_valid_d = 1'b1;
                  mem_addr_d    = RESET_PC;
                  pc_clear      = 1'b1;
               end
            end else if (fire) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = RESET_PC + ADDR_W'(count_q) * ADDR_W'(WORD_BYTES);
               mem_wdata_d = bus.LoadData;
               count_d     = count_q + CNT_W'(1);
`ifdef LOAD_CHECKSUM_EN
               sum_d       = sum_q + bus.LoadData;
`endif
               if (bus.LoadLast) begin
                  load_ready_d = 1'b0;
                  pend_d       = 1'b1;
`ifdef LOAD_CHECKSUM_EN
                  csum_ok_d    = (sum_d == bus.ExpectedSum);
                  pend_state_d = csum_ok_d ? ST_RUN : ST_ERROR;
`else
                  pend_state_d = ST_RUN;
`endif
               end else if (count_q == CNT_W'(MEM_WORDS - 1)) begin
                  load_ready_d = 1'b0;
                  pend_d       = 1'b1;
                  pend_state_d = ST_ERROR;
               end
            end
         end

         ST_RUN: begin
            if (bus.Halt) begin
               state_d       = ST_HALTED;
               fetch_valid_d = 1'b0;
            end else if (bus.BranchTaken) begin
               pc_load = 1'b1;
            end else if (!bus.Stall) begin
               pc_inc = 1'b1;
            end
            mem_addr_d = next_pc;
            if (oor) begin
               state_d       = ST_ERROR;
               fetch_valid_d = 1'b0;
            end
         end

         ST_HALTED, ST_ERROR: begin
            if (bus.Restart) begin
               state_d       = ST_RUN;
               fetch_valid_d = 1'b1;
               mem_addr_d    = RESET_PC;
               pc_clear      = 1'b1;
            end
         end

         default: state_d = ST_ERROR;
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= ST_LOAD;
         load_ready_q  <= 1'b1;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= RESET_PC;
         mem_wdata_q   <= '0;
         fetch_valid_q <= 1'b0;
         count_q       <= '0;
         pend_q        <= 1'b0;
         pend_state_q  <= ST_LOAD;
`ifdef LOAD_CHECKSUM_EN
         sum_q         <= '0;
         csum_ok_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         load_ready_q  <= load_ready_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         fetch_valid_q <= fetch_valid_d;
         count_q       <= count_d;
         pend_q        <= pend_d;
         pend_state_q  <= pend_state_d;
`ifdef LOAD_CHECKSUM_EN
         sum_q         <= sum_d;
         csum_ok_q     <= csum_ok_d;
`endif
      end
   end

   assign bus.LoadReady      = load_ready_q;
   assign bus.MemWriteEnable = mem_we_q;
   assign bus.MemAddr        = mem_addr_q;
   assign bus.MemWriteData   = mem_wdata_q;
   assign bus.PCAddress      = pc;
   assign bus.FetchValid     = fetch_valid_q;
   assign bus.State          = state_q;
`ifdef LOAD_CHECKSUM_EN
   assign bus.ChecksumOk     = csum_ok_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; a second instance uses MEM_WORDS=4.
// Optional feature macro: LOAD_CHECKSUM_EN enables the checksum scenario.
module tb_fetch_controller;

   logic Clk = 1'b0;
   logic Rst_n;
   int   total = 0;
   int   bad   = 0;

   fetch_controller_if bus ();
   fetch_controller_if sbus ();

   fetch_controller #(.MEM_WORDS(1024), .RESET_PC(32'h0)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus));
   fetch_controller #(.MEM_WORDS(4), .RESET_PC(32'h0)) u_small (
      .Clk(Clk), .Rst_n(Rst_n), .bus(sbus));

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.LoadValid = 0; bus.LoadData = '0; bus.LoadLast = 0; bus.Stall = 0;
      bus.BranchTaken = 0; bus.BranchTarget = '0; bus.Halt = 0; bus.Restart = 0;
      sbus.LoadValid = 0; sbus.LoadData = '0; sbus.LoadLast = 0; sbus.Stall = 0;
      sbus.BranchTaken = 0; sbus.BranchTarget = '0; sbus.Halt = 0; sbus.Restart = 0;
`ifdef LOAD_CHECKSUM_EN
      bus.ExpectedSum = '0; sbus.ExpectedSum = '0;
`endif
   endtask

   task automatic do_reset();
      Rst_n = 0;
      idle_inputs();
      tick();
      Rst_n = 1;
   endtask

   task automatic test_reset();
      Rst_n = 1;
      idle_inputs();
      #2 Rst_n = 0;
      #1;
      total++; if (bus.State !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.State); end
      total++; if (bus.PCAddress !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.PCAddress); end
      total++; if (bus.LoadReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.LoadReady); end
      total++; if (bus.MemWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.MemWriteEnable); end
      total++; if (bus.MemAddr !== 32'h0 || bus.MemWriteData !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=0/0", bus.MemAddr, bus.MemWriteData); end
      total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", bus.FetchValid); end
      tick();
      Rst_n = 1;
   endtask

   // Small memory: 4 words without Last overflow into ERROR, then restart and run off the end
   task automatic test_overflow();
      sbus.LoadValid = 1; sbus.LoadLast = 0;
      for (int i = 0; i < 4; i++) begin
         sbus.LoadData = 32'(i + 1);
         tick();
         total++;
         if (sbus.MemWriteEnable !== 1'b1 || sbus.MemAddr !== 32'(4*i) || sbus.MemWriteData !== 32'(i + 1)) begin
            bad++; $display("FAIL ovf_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i,
               sbus.MemWriteEnable, sbus.MemAddr, sbus.MemWriteData, 32'(4*i), 32'(i + 1));
         end
      end
      total++; if (sbus.LoadReady !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", sbus.LoadReady); end
      sbus.LoadData = 32'h99;
      tick();
      total++; if (sbus.State !== 2'd3 || sbus.MemWriteEnable !== 1'b0) begin bad++; $display("FAIL ovf_error got st=%0d we=%b exp st=3 we=0", sbus.State, sbus.MemWriteEnable); end
      tick();
      total++; if (sbus.MemWriteEnable !== 1'b0 || sbus.LoadReady !== 1'b0) begin bad++; $display("FAIL ovf_noaccept got we=%b rdy=%b exp 0/0", sbus.MemWriteEnable, sbus.LoadReady); end
      sbus.LoadValid = 0;
      sbus.Restart = 1;
      tick();
      sbus.Restart = 0;
      total++; if (sbus.State !== 2'd1 || sbus.PCAddress !== 32'h0 || sbus.FetchValid !== 1'b1) begin bad++; $display("FAIL ovf_restart got st=%0d pc=%h fv=%b exp 1/0/1", sbus.State, sbus.PCAddress, sbus.FetchValid); end
      tick(); tick(); tick();
      total++; if (sbus.PCAddress !== 32'hC || sbus.MemAddr !== 32'hC) begin bad++; $display("FAIL ovf_lastword got pc=%h a=%h exp c/c", sbus.PCAddress, sbus.MemAddr); end
      tick();
      total++; if (sbus.State !== 2'd3 || sbus.PCAddress !== 32'hC || sbus.FetchValid !== 1'b0) begin bad++; $display("FAIL ovf_nowrap got st=%0d pc=%h fv=%b exp 3/c/0", sbus.State, sbus.PCAddress, sbus.FetchValid); end
   endtask

   // Three-word program with LoadValid held, then sequential fetch
   task automatic test_load();
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
`ifdef LOAD_CHECKSUM_EN
      bus.ExpectedSum = 32'h66;
`endif
      bus.LoadValid = 1;
      for (int i = 0; i < 3; i++) begin
         bus.LoadData = words[i];
         bus.LoadLast = (i == 2);
         tick();
         total++;
         if (bus.MemWriteEnable !== 1'b1 || bus.MemAddr !== 32'(4*i) || bus.MemWriteData !== words[i] || bus.State !== 2'd0) begin
            bad++; $display("FAIL load_write%0d got we=%b a=%h d=%h st=%0d exp we=1 a=%h d=%h st=0", i,
               bus.MemWriteEnable, bus.MemAddr, bus.MemWriteData, bus.State, 32'(4*i), words[i]);
         end
      end
      total++; if (bus.LoadReady !== 1'b0) begin bad++; $display("FAIL load_ready_drop got=%b exp=0", bus.LoadReady); end
      bus.LoadLast = 0;
      bus.LoadData = 32'hDEAD;
      tick();
      bus.LoadValid = 0;
      total++; if (bus.State !== 2'd1 || bus.PCAddress !== 32'h0 || bus.FetchValid !== 1'b1 || bus.MemWriteEnable !== 1'b0) begin
         bad++; $display("FAIL load_to_run got st=%0d pc=%h fv=%b we=%b exp 1/0/1/0", bus.State, bus.PCAddress, bus.FetchValid, bus.MemWriteEnable);
      end
      bus.Restart = 1;
      tick();
      bus.Restart = 0;
      total++; if (bus.PCAddress !== 32'h4 || bus.MemAddr !== 32'h4) begin bad++; $display("FAIL run_pc4 got pc=%h a=%h exp 4/4", bus.PCAddress, bus.MemAddr); end
      tick();
      total++; if (bus.PCAddress !== 32'h8) begin bad++; $display("FAIL run_pc8 got=%h exp=8", bus.PCAddress); end
   endtask

   // Stall hold, branch overriding stall, out-of-range branch
   task automatic test_stall_branch();
      bus.Stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.PCAddress !== 32'h8) begin bad++; $display("FAIL stall%0d got=%h exp=8", i, bus.PCAddress); end
      end
      bus.BranchTaken = 1; bus.BranchTarget = 32'h13;
      tick();
      bus.Stall = 0; bus.BranchTaken = 0;
      total++; if (bus.PCAddress !== 32'h10 || bus.MemAddr !== 32'h10) begin bad++; $display("FAIL branch_align got pc=%h a=%h exp 10/10", bus.PCAddress, bus.MemAddr); end
      tick();
      total++; if (bus.PCAddress !== 32'h14) begin bad++; $display("FAIL after_branch got=%h exp=14", bus.PCAddress); end
      bus.BranchTaken = 1; bus.BranchTarget = 32'h1000;
      tick();
      bus.BranchTaken = 0;
      total++; if (bus.State !== 2'd3 || bus.PCAddress !== 32'h14 || bus.FetchValid !== 1'b0) begin bad++; $display("FAIL branch_oor got st=%0d pc=%h fv=%b exp 3/14/0", bus.State, bus.PCAddress, bus.FetchValid); end
      bus.Restart = 1;
      tick();
      bus.Restart = 0;
      total++; if (bus.State !== 2'd1 || bus.PCAddress !== 32'h0) begin bad++; $display("FAIL err_restart got st=%0d pc=%h exp 1/0", bus.State, bus.PCAddress); end
   endtask

   // Halt freezes PC, restart refetches, async reset mid-run
   task automatic test_halt_reset();
      bus.BranchTaken = 1; bus.BranchTarget = 32'hC;
      tick();
      bus.BranchTaken = 0;
      bus.Halt = 1;
      tick();
      bus.Halt = 0;
      total++; if (bus.State !== 2'd2 || bus.FetchValid !== 1'b0 || bus.PCAddress !== 32'hC) begin bad++; $display("FAIL halt got st=%0d fv=%b pc=%h exp 2/0/c", bus.State, bus.FetchValid, bus.PCAddress); end
      bus.BranchTaken = 1; bus.BranchTarget = 32'h40;
      tick();
      bus.BranchTaken = 0;
      total++; if (bus.State !== 2'd2 || bus.PCAddress !== 32'hC || bus.LoadReady !== 1'b0) begin bad++; $display("FAIL halt_hold got st=%0d pc=%h rdy=%b exp 2/c/0", bus.State, bus.PCAddress, bus.LoadReady); end
      bus.Restart = 1;
      tick();
      bus.Restart = 0;
      tick();
      total++; if (bus.State !== 2'd1 || bus.PCAddress !== 32'h4) begin bad++; $display("FAIL halt_restart got st=%0d pc=%h exp 1/4", bus.State, bus.PCAddress); end
      #2 Rst_n = 0;
      #1;
      total++; if (bus.State !== 2'd0 || bus.PCAddress !== 32'h0 || bus.FetchValid !== 1'b0 || bus.LoadReady !== 1'b1) begin
         bad++; $display("FAIL async_reset got st=%0d pc=%h fv=%b rdy=%b exp 0/0/0/1", bus.State, bus.PCAddress, bus.FetchValid, bus.LoadReady);
      end
      tick();
      Rst_n = 1;
   endtask

   // Gapped handshake, then a one-word program
   task automatic test_toggle_oneword();
      int writes = 0;
`ifdef LOAD_CHECKSUM_EN
      bus.ExpectedSum = 32'h143;
`endif
      bus.LoadValid = 1; bus.LoadData = 32'hA1; bus.LoadLast = 0;
      tick(); writes += int'(bus.MemWriteEnable);
      total++; if (bus.MemAddr !== 32'h0 || bus.MemWriteData !== 32'hA1) begin bad++; $display("FAIL tog_w0 got a=%h d=%h exp 0/a1", bus.MemAddr, bus.MemWriteData); end
      bus.LoadValid = 0; bus.LoadData = 32'hBAD; bus.LoadLast = 1;
      tick(); writes += int'(bus.MemWriteEnable);
      total++; if (bus.MemWriteEnable !== 1'b0 || bus.State !== 2'd0 || bus.LoadReady !== 1'b1) begin bad++; $display("FAIL tog_gap got we=%b st=%0d rdy=%b exp 0/0/1", bus.MemWriteEnable, bus.State, bus.LoadReady); end
      bus.LoadValid = 1; bus.LoadData = 32'hA2; bus.LoadLast = 1;
      tick(); writes += int'(bus.MemWriteEnable);
      total++; if (bus.MemAddr !== 32'h4 || bus.MemWriteData !== 32'hA2) begin bad++; $display("FAIL tog_w1 got a=%h d=%h exp 4/a2", bus.MemAddr, bus.MemWriteData); end
      bus.LoadValid = 0; bus.LoadLast = 0;
      tick(); writes += int'(bus.MemWriteEnable);
      total++; if (writes != 2 || bus.State !== 2'd1) begin bad++; $display("FAIL tog_count got writes=%0d st=%0d exp 2/1", writes, bus.State); end
      do_reset();
`ifdef LOAD_CHECKSUM_EN
      bus.ExpectedSum = 32'h55;
`endif
      bus.LoadValid = 1; bus.LoadData = 32'h55; bus.LoadLast = 1;
      tick();
      bus.LoadValid = 0; bus.LoadLast = 0;
      total++; if (bus.MemWriteEnable !== 1'b1 || bus.MemAddr !== 32'h0 || bus.LoadReady !== 1'b0) begin bad++; $display("FAIL one_write got we=%b a=%h rdy=%b exp 1/0/0", bus.MemWriteEnable, bus.MemAddr, bus.LoadReady); end
      tick();
      total++; if (bus.State !== 2'd1 || bus.PCAddress !== 32'h0 || bus.FetchValid !== 1'b1) begin bad++; $display("FAIL one_run got st=%0d pc=%h fv=%b exp 1/0/1", bus.State, bus.PCAddress, bus.FetchValid); end
   endtask

`ifdef LOAD_CHECKSUM_EN
   task automatic test_checksum();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         bus.ExpectedSum = (k == 0) ? 32'd6 : 32'd7;
         bus.LoadValid = 1;
         for (int i = 0; i < 3; i++) begin
            bus.LoadData = 32'(i + 1);
            bus.LoadLast = (i == 2);
            tick();
         end
         bus.LoadValid = 0; bus.LoadLast = 0;
         tick();
         total++;
         if (bus.State !== ((k == 0) ? 2'd1 : 2'd3) || bus.ChecksumOk !== ((k == 0) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL csum%0d got st=%0d ok=%b", k, bus.State, bus.ChecksumOk);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_overflow();
      test_load();
      test_stall_branch();
      test_halt_reset();
      test_toggle_oneword();
`ifdef LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
